axis_deadlock_monitor_n: RTL and testbench

- Parametrised kernel-level deadlock monitor for HLS co-simulation and on-chip debug.
- Watches N AXI-Stream port block flags plus M sub-instance idle/block flags.
- Debounces a stall over a configurable confirm window, then latches a snapshot of the blocking ports, counts events and stall duration, and raises a sticky deadlock flag until software clears it.
- Generalises the fixed 2-port / fixed-debounce monitor: any port count, configurable startup blanking, pattern-stability check, recovery detection, counters.

---
 rtl/axis_deadlock_monitor_n.sv | 152 +++++++++++++++
 tb/tb_axis_deadlock_monitor_n.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/axis_deadlock_monitor_n.sv
// Kernel-level deadlock monitor: debounces a stall over a stable-pattern confirm window,
// then latches the blocking-port snapshot, counts events and stall time, and holds a sticky flag.
//
// state       | meaning
// ST_STARTUP  | post-reset blanking, inputs ignored
// ST_MONITOR  | idle watch for a stall condition
// ST_CONFIRM  | stall seen, waiting for a stable pattern to persist
// ST_DEADLOCK | deadlock confirmed, waiting for recovery or clear
module axis_deadlock_monitor_n #(
    parameter int NUM_AXIS       = 2,
    parameter int NUM_INST       = 2,
    parameter int STARTUP_CYCLES = 10,
    parameter int CONFIRM_CYCLES = 2,
    parameter int CNT_W          = 16,
    parameter int EVT_W          = 8
) (
    input  logic                kernel_monitor_clock,
    input  logic                kernel_monitor_reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_INST-1:0] inst_block_sigs,
    input  logic                clear,
    output logic                kernel_block,
    output logic                deadlock,
    output logic                in_deadlock,
    output logic                report_valid,
    output logic [NUM_AXIS-1:0] blocked_ports,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic [EVT_W-1:0]    deadlock_events
);

    localparam int              SU_W    = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
    localparam bit              SU_SKIP = (STARTUP_CYCLES == 0);
    localparam logic [SU_W-1:0] SU_LAST = SU_SKIP ? '0 : SU_W'(STARTUP_CYCLES - 1);
    localparam int              CF_W    = $clog2(CONFIRM_CYCLES + 1);
    localparam logic [CF_W-1:0] CF_LAST = CF_W'(CONFIRM_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STARTUP,
        ST_MONITOR,
        ST_CONFIRM,
        ST_DEADLOCK
    } state_t;

    state_t              state, state_nxt;
    logic [SU_W-1:0]     su_cnt, su_cnt_nxt;
    logic [CF_W-1:0]     cf_cnt, cf_cnt_nxt;
    logic [NUM_AXIS-1:0] pat, pat_nxt;
    logic                stall_cond;
    logic                clr_act;
    logic                enter_dl;

    assign stall_cond = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs);
    assign clr_act    = clear && (state != ST_STARTUP);

    always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
        if (!kernel_monitor_reset) begin
            state  <= ST_STARTUP;
            su_cnt <= '0;
            cf_cnt <= '0;
            pat    <= '0;
        end else begin
            state  <= state_nxt;
            su_cnt <= su_cnt_nxt;
            cf_cnt <= cf_cnt_nxt;
            pat    <= pat_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        su_cnt_nxt = su_cnt;
        cf_cnt_nxt = cf_cnt;
        pat_nxt    = pat;
        enter_dl   = 1'b0;
        case (state)
            ST_STARTUP: begin
                if (SU_SKIP || su_cnt == SU_LAST) state_nxt = ST_MONITOR;
                else su_cnt_nxt = su_cnt + 1'b1;
            end
            ST_MONITOR: begin
                if (stall_cond) begin
                    if (CONFIRM_CYCLES == 1) begin
                        enter_dl = 1'b1;
                    end else begin
                        state_nxt  = ST_CONFIRM;
                        cf_cnt_nxt = CF_W'(1);
                        pat_nxt    = axis_block_sigs;
                    end
                end
            end
            ST_CONFIRM: begin
                if (!stall_cond) begin
                    state_nxt  = ST_MONITOR;
                    cf_cnt_nxt = '0;
                end else if (axis_block_sigs != pat) begin
                    // a shifting pattern is traffic moving, not a deadlock: restart the window
                    cf_cnt_nxt = CF_W'(1);
                    pat_nxt    = axis_block_sigs;
                end else if (cf_cnt == CF_LAST) begin
                    enter_dl = 1'b1;
                end else begin
                    cf_cnt_nxt = cf_cnt + 1'b1;
                end
            end
            ST_DEADLOCK: begin
                if (!stall_cond) state_nxt = ST_MONITOR;
            end
            default: state_nxt = ST_STARTUP;
        endcase
        if (enter_dl) begin
            state_nxt  = ST_DEADLOCK;
            cf_cnt_nxt = '0;
        end
        // clear beats a coincident entry; software must see a fresh confirmation
        if (clr_act) begin
            enter_dl = 1'b0;
            if (state_nxt == ST_DEADLOCK) state_nxt = ST_MONITOR;
        end
    end

    always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
        if (!kernel_monitor_reset) begin
            kernel_block    <= 1'b0;
            deadlock        <= 1'b0;
            in_deadlock     <= 1'b0;
            report_valid    <= 1'b0;
            blocked_ports   <= '0;
            stall_cycles    <= '0;
            deadlock_events <= '0;
        end else begin
            kernel_block <= (state != ST_STARTUP) && stall_cond;
            in_deadlock  <= (state_nxt == ST_DEADLOCK);
            report_valid <= enter_dl;
            if (clr_act) begin
                deadlock        <= 1'b0;
                blocked_ports   <= '0;
                stall_cycles    <= '0;
                deadlock_events <= '0;
            end else begin
                if (enter_dl) begin
                    blocked_ports <= axis_block_sigs;
                    deadlock      <= 1'b1;
                    if (deadlock_events != '1) deadlock_events <= deadlock_events + 1'b1;
                end
                if ((state == ST_CONFIRM || state == ST_DEADLOCK) && stall_cycles != '1)
                    stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_deadlock_monitor_n.sv
// Directed bench for axis_deadlock_monitor_n: a cycle table on the default configuration,
// plus hand sequences for pattern restart, direct confirm, saturation and async reset.
module tb_axis_deadlock_monitor_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // instance A: defaults
    logic        rst_a = 1'b0, clr_a = 1'b0;
    logic [1:0]  axis_a = '0, idle_a = '0, blk_a = '0;
    logic        kb_a, dl_a, ind_a, rv_a;
    logic [1:0]  bp_a;
    logic [15:0] sc_a;
    logic [7:0]  ev_a;

    // instance B: short startup, three-cycle confirm
    logic        rst_b = 1'b0;
    logic [1:0]  axis_b = '0;
    logic        kb_b, dl_b, ind_b, rv_b;
    logic [1:0]  bp_b;
    logic [15:0] sc_b;
    logic [7:0]  ev_b;

    // instance C: five ports, 2-bit event counter, no startup, single-cycle confirm
    logic        rst_c = 1'b0;
    logic [4:0]  axis_c = '0;
    logic        kb_c, dl_c, ind_c, rv_c;
    logic [4:0]  bp_c;
    logic [15:0] sc_c;
    logic [1:0]  ev_c;

    axis_deadlock_monitor_n dut_a (
        .kernel_monitor_clock(clk), .kernel_monitor_reset(rst_a),
        .axis_block_sigs(axis_a), .inst_idle_sigs(idle_a), .inst_block_sigs(blk_a),
        .clear(clr_a), .kernel_block(kb_a), .deadlock(dl_a), .in_deadlock(ind_a),
        .report_valid(rv_a), .blocked_ports(bp_a), .stall_cycles(sc_a),
        .deadlock_events(ev_a));

    axis_deadlock_monitor_n #(.STARTUP_CYCLES(2), .CONFIRM_CYCLES(3)) dut_b (
        .kernel_monitor_clock(clk), .kernel_monitor_reset(rst_b),
        .axis_block_sigs(axis_b), .inst_idle_sigs(2'b00), .inst_block_sigs(2'b00),
        .clear(1'b0), .kernel_block(kb_b), .deadlock(dl_b), .in_deadlock(ind_b),
        .report_valid(rv_b), .blocked_ports(bp_b), .stall_cycles(sc_b),
        .deadlock_events(ev_b));

    axis_deadlock_monitor_n #(.NUM_AXIS(5), .EVT_W(2), .STARTUP_CYCLES(0),
                              .CONFIRM_CYCLES(1)) dut_c (
        .kernel_monitor_clock(clk), .kernel_monitor_reset(rst_c),
        .axis_block_sigs(axis_c), .inst_idle_sigs(2'b00), .inst_block_sigs(2'b00),
        .clear(1'b0), .kernel_block(kb_c), .deadlock(dl_c), .in_deadlock(ind_c),
        .report_valid(rv_c), .blocked_ports(bp_c), .stall_cycles(sc_c),
        .deadlock_events(ev_c));

    typedef struct {
        logic [1:0] axis, idle, blk;
        logic       clr;
        logic       kb, dl, ind, rv;
        logic [1:0] bp;
        int         sc, ev;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [1:0] axis, input logic [1:0] idle, input logic [1:0] blk,
                       input logic clr, input logic kb, input logic dl, input logic ind,
                       input logic rv, input logic [1:0] bp, input int sc, input int ev);
        vec_t v;
        v.axis = axis; v.idle = idle; v.blk = blk; v.clr = clr;
        v.kb = kb; v.dl = dl; v.ind = ind; v.rv = rv; v.bp = bp; v.sc = sc; v.ev = ev;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    initial begin
        // cycle table for A; each row is the input in cycle k and the outputs seen in cycle k+1
        // fields: axis idle blk clr | kb dl ind rv bp sc ev
        for (int k = 0; k < 10; k++)   // blanking: X and clear must be ignored
            add(2'b01, 2'b10, (k < 5) ? 2'bxx : 2'b00, (k == 3), 0,0,0,0, 2'b00, 0, 0);
        add(2'b01, 2'b10, 2'b00, 0,  1,0,0,0, 2'b00, 0, 0);
        add(2'b01, 2'b10, 2'b00, 0,  1,1,1,1, 2'b01, 1, 1);
        add(2'b01, 2'b10, 2'b00, 0,  1,1,1,0, 2'b01, 2, 1);
        add(2'b00, 2'b10, 2'b00, 0,  0,1,0,0, 2'b01, 3, 1);   // recovery keeps snapshot
        add(2'b10, 2'b10, 2'b00, 0,  1,1,0,0, 2'b01, 3, 1);
        add(2'b10, 2'b10, 2'b00, 0,  1,1,1,1, 2'b10, 4, 2);
        add(2'b10, 2'b10, 2'b00, 1,  1,0,0,0, 2'b00, 0, 0);   // clear in DEADLOCK
        add(2'b10, 2'b10, 2'b00, 0,  1,0,0,0, 2'b00, 0, 0);
        add(2'b10, 2'b10, 2'b00, 0,  1,1,1,1, 2'b10, 1, 1);
        add(2'b00, 2'b10, 2'b00, 0,  0,1,0,0, 2'b10, 2, 1);
        add(2'b01, 2'b10, 2'b00, 0,  1,1,0,0, 2'b10, 2, 1);
        add(2'b01, 2'b10, 2'b00, 1,  1,0,0,0, 2'b00, 0, 0);   // clear beats entry
        add(2'b00, 2'b10, 2'b00, 0,  0,0,0,0, 2'b00, 0, 0);
        for (int i = 0; i < 5; i++) begin                      // one-cycle glitches
            add(2'b01, 2'b10, 2'b00, 0,  1,0,0,0, 2'b00, i, 0);
            add(2'b00, 2'b10, 2'b00, 0,  0,0,0,0, 2'b00, i + 1, 0);
        end
        add(2'b00, 2'b00, 2'b01, 0,  1,0,0,0, 2'b00, 5, 0);   // internal block
        add(2'b00, 2'b11, 2'b01, 0,  0,0,0,0, 2'b00, 6, 0);   // all idle masks it
        add(2'b11, 2'b11, 2'b00, 0,  0,0,0,0, 2'b00, 6, 0);
        add(2'b00, 2'b00, 2'b00, 0,  0,0,0,0, 2'b00, 6, 0);
        add(2'b00, 2'b00, 2'b00, 1,  0,0,0,0, 2'b00, 0, 0);   // clear in MONITOR

        #1;
        chk("a_reset", 64'({kb_a, dl_a, ind_a, rv_a, bp_a, sc_a, ev_a}), 64'd0);
        @(negedge clk);
        rst_a = 1'b1;
        foreach (vecs[k]) begin
            axis_a = vecs[k].axis; idle_a = vecs[k].idle;
            blk_a  = vecs[k].blk;  clr_a  = vecs[k].clr;
            @(posedge clk); #1;
            chk($sformatf("vec%0d", k),
                64'({kb_a, dl_a, ind_a, rv_a, bp_a, sc_a, ev_a}),
                64'({vecs[k].kb, vecs[k].dl, vecs[k].ind, vecs[k].rv, vecs[k].bp,
                     16'(vecs[k].sc), 8'(vecs[k].ev)}));
        end

        // B: alternating pattern keeps restarting the window; a held pattern confirms
        @(negedge clk);
        axis_b = 2'b10;
        rst_b  = 1'b1;
        for (int k = 0; k < 15; k++) begin
            axis_b = (k >= 12) ? 2'b10 : ((k % 2 == 0) ? 2'b10 : 2'b01);
            @(posedge clk); #1;
            if (k < 14)
                chk($sformatf("b_toggle%0d", k), 64'({kb_b, ind_b, rv_b}),
                    64'({(k >= 2), 1'b0, 1'b0}));
        end
        chk("b_entry", 64'({ind_b, rv_b, dl_b, bp_b, sc_b, ev_b}),
            64'({1'b1, 1'b1, 1'b1, 2'b10, 16'd12, 8'd1}));
        @(posedge clk); #1;
        chk("b_pulse_once", 64'({ind_b, rv_b, sc_b}), 64'({1'b1, 1'b0, 16'd13}));

        // C: direct entry each stall cycle, event counter saturates at 3
        @(negedge clk);
        rst_c = 1'b1;
        @(posedge clk); #1;
        chk("c_startup0", 64'({kb_c, dl_c, ind_c, rv_c, ev_c}), 64'd0);
        for (int i = 0; i < 4; i++) begin
            logic [4:0] p;
            logic [1:0] e;
            p = 5'(1 << i);
            e = (i < 3) ? 2'(i + 1) : 2'd3;
            axis_c = p;
            @(posedge clk); #1;
            chk($sformatf("c_enter%0d", i), 64'({ind_c, rv_c, dl_c, bp_c, ev_c}),
                64'({1'b1, 1'b1, 1'b1, p, e}));
            axis_c = 5'b00000;
            @(posedge clk); #1;
            chk($sformatf("c_recover%0d", i), 64'({ind_c, rv_c, dl_c, bp_c, ev_c}),
                64'({1'b0, 1'b0, 1'b1, p, e}));
        end
        axis_c = 5'b10101;
        @(posedge clk); #1;
        chk("c_sat", 64'({ind_c, rv_c, bp_c, ev_c}), 64'({1'b1, 1'b1, 5'b10101, 2'd3}));
        #2;
        rst_c = 1'b0;
        #1;
        chk("c_async_reset", 64'({kb_c, dl_c, ind_c, rv_c, bp_c, sc_c, ev_c}), 64'd0);
        @(posedge clk); #1;
        chk("c_reset_held", 64'({kb_c, dl_c, ind_c, rv_c, bp_c, sc_c, ev_c}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
